// File: rtl/mmio_uart_port.sv
// Memory-mapped UART port: decodes the UART register window, prefetches RX bytes
// into a small circular buffer and pushes TX bytes, optionally stalling the core.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for req; decodes and completes immediate accesses
//   RX_WAIT | blocking RX read on empty buffer; waits for a byte or timeout
//   TX_WAIT | blocking TX write on full FIFO; waits for space or timeout
//   RESP    | ack (and err) high for one cycle, then back to IDLE
module mmio_uart_port #(
   parameter int                ADDR_W    = 10,
   parameter logic [ADDR_W-1:0] RX_ADDR   = 10'h000,
   parameter logic [ADDR_W-1:0] RXST_ADDR = 10'h004,
   parameter logic [ADDR_W-1:0] TXST_ADDR = 10'h008,
   parameter logic [ADDR_W-1:0] TX_ADDR   = 10'h00C,
   parameter int                RXBUF_D   = 4,
   parameter bit                BLOCKING  = 1'b1,
   parameter int                TIMEOUT   = 0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ack,
   output logic              err,
   input  logic [7:0]        uart_rx_data,
   input  logic              empty,
   output logic              uart_rd_en,
   output logic [7:0]        uart_tx_data,
   input  logic              full,
   output logic              uart_wr_en
);

   localparam int PW  = $clog2(RXBUF_D);
   localparam int CW  = PW + 1;
   localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0]  DEPTH   = CW'(RXBUF_D);
   // Terminal count is one below TIMEOUT so that exactly TIMEOUT cycles are spent waiting.
   localparam logic [WCW-1:0] WAIT_TC = (TIMEOUT == 0) ? '0 : WCW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      RX_WAIT,
      TX_WAIT,
      RESP
   } state_t;

   state_t         state;
   logic [7:0]     rxBuf [RXBUF_D];
   logic [PW-1:0]  wrPtr;
   logic [PW-1:0]  rdPtr;
   logic [CW-1:0]  cnt;
   logic [WCW-1:0] waitCnt;
   logic [7:0]     txByte;

   logic       push;
   logic       pop;
   logic       bufEmpty;
   logic       isRx;
   logic       isRxSt;
   logic       isTxSt;
   logic       isTx;
   logic [7:0] headByte;
   logic       unusedWdataHi;

   assign unusedWdataHi = &{1'b0, wdata[31:8]};

   always_comb begin
      bufEmpty = (cnt == '0);
      headByte = rxBuf[rdPtr];
      isRx     = (addr == RX_ADDR);
      isRxSt   = (addr == RXST_ADDR);
      isTxSt   = (addr == TXST_ADDR);
      isTx     = (addr == TX_ADDR);
      push     = rstn && !empty && (cnt != DEPTH);
      pop      = ((state == IDLE) && req && !we && isRx && !bufEmpty)
              || ((state == RX_WAIT) && !bufEmpty);
   end

   assign uart_rd_en = push;

   always_ff @(posedge clk) begin
      if (push) begin
         rxBuf[wrPtr] <= uart_rx_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wrPtr <= '0;
         rdPtr <= '0;
         cnt   <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + PW'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PW'(1);
         end
         if (push && !pop) begin
            cnt <= cnt + CW'(1);
         end else if (pop && !push) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         waitCnt      <= '0;
         txByte       <= '0;
         rdata        <= '0;
         ack          <= 1'b0;
         err          <= 1'b0;
         uart_tx_data <= '0;
         uart_wr_en   <= 1'b0;
      end else begin
         // Response outputs are single-cycle pulses unless a branch below sets them.
         ack        <= 1'b0;
         err        <= 1'b0;
         rdata      <= '0;
         uart_wr_en <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  waitCnt <= '0;
                  txByte  <= wdata[7:0];
                  state   <= RESP;
                  ack     <= 1'b1;
                  if (!we && isRx) begin
                     if (!bufEmpty) begin
                        rdata <= {24'b0, headByte};
                     end else if (BLOCKING) begin
                        state <= RX_WAIT;
                        ack   <= 1'b0;
                     end else begin
                        err <= 1'b1;
                     end
                  end else if (!we && isRxSt) begin
                     rdata <= {16'b0, 8'(cnt), 7'b0, !bufEmpty};
                  end else if (!we && isTxSt) begin
                     rdata <= {31'b0, !full};
                  end else if (we && isTx) begin
                     if (!full) begin
                        uart_wr_en   <= 1'b1;
                        uart_tx_data <= wdata[7:0];
                     end else if (BLOCKING) begin
                        state <= TX_WAIT;
                        ack   <= 1'b0;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
            end
            RX_WAIT: begin
               waitCnt <= waitCnt + WCW'(1);
               if (!bufEmpty) begin
                  rdata <= {24'b0, headByte};
                  ack   <= 1'b1;
                  state <= RESP;
               end else if ((TIMEOUT != 0) && (waitCnt == WAIT_TC)) begin
                  err   <= 1'b1;
                  ack   <= 1'b1;
                  state <= RESP;
               end
            end
            TX_WAIT: begin
               waitCnt <= waitCnt + WCW'(1);
               if (!full) begin
                  uart_wr_en   <= 1'b1;
                  uart_tx_data <= txByte;
                  ack          <= 1'b1;
                  state        <= RESP;
               end else if ((TIMEOUT != 0) && (waitCnt == WAIT_TC)) begin
                  err   <= 1'b1;
                  ack   <= 1'b1;
                  state <= RESP;
               end
            end
            RESP: begin
               waitCnt <= '0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_port.sv
// Scoreboard bench for mmio_uart_port: three instances (blocking/no timeout,
// blocking/timeout 8, nonblocking); only the instance under test is out of reset.
module tb_mmio_uart_port;

   localparam logic [9:0] RXA   = 10'h000;
   localparam logic [9:0] RXSTA = 10'h004;
   localparam logic [9:0] TXSTA = 10'h008;
   localparam logic [9:0] TXA   = 10'h00C;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic [2:0]  rstn;
   logic        req;
   logic        we;
   logic [9:0]  addr;
   logic [31:0] wdata;
   logic        full;
   logic [7:0]  rxHead;
   logic        rxEmpty;
   logic [31:0] rdata [3];
   logic [7:0]  txData [3];
   logic [2:0]  ack;
   logic [2:0]  err;
   logic [2:0]  rdEn;
   logic [2:0]  wrEn;

   logic [7:0]  rxMem [64];
   int          rxWr = 0;
   int          rxRd = 0;
   int          cyc = 0;
   int          checks = 0;
   int          passed = 0;
   exp_t        expQ [$];
   logic [7:0]  txQ [$];
   logic [2:0]  prevAck = 3'b000;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign rxEmpty = (rxWr == rxRd);
   assign rxHead  = rxMem[rxRd[5:0]];

   always @(posedge clk) begin
      if ((|rdEn) && (rxRd != rxWr)) rxRd <= rxRd + 1;
   end

   mmio_uart_port #(.BLOCKING(1'b1), .TIMEOUT(0)) duA (
      .clk(clk), .rstn(rstn[0]), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .uart_rx_data(rxHead), .empty(rxEmpty),
      .uart_rd_en(rdEn[0]), .uart_tx_data(txData[0]), .full(full), .uart_wr_en(wrEn[0]));

   mmio_uart_port #(.BLOCKING(1'b1), .TIMEOUT(8)) duB (
      .clk(clk), .rstn(rstn[1]), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .uart_rx_data(rxHead), .empty(rxEmpty),
      .uart_rd_en(rdEn[1]), .uart_tx_data(txData[1]), .full(full), .uart_wr_en(wrEn[1]));

   mmio_uart_port #(.BLOCKING(1'b0), .TIMEOUT(0)) duC (
      .clk(clk), .rstn(rstn[2]), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata[2]), .ack(ack[2]), .err(err[2]), .uart_rx_data(rxHead), .empty(rxEmpty),
      .uart_rd_en(rdEn[2]), .uart_tx_data(txData[2]), .full(full), .uart_wr_en(wrEn[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic pushRx(input logic [7:0] b);
      rxMem[rxWr[5:0]] = b;
      rxWr = rxWr + 1;
   endtask

   // Issue one access at a negedge; expected response goes to the scoreboard.
   task automatic access(input logic w, input logic [9:0] a, input logic [31:0] d,
                         input logic [31:0] expD, input logic expE, input int waits,
                         input int inst);
      exp_t e;
      int   n;
      e.rdata = expD;
      e.err   = expE;
      e.cyc   = cyc + 1 + waits;
      expQ.push_back(e);
      req = 1'b1; we = w; addr = a; wdata = d;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((ack[inst] !== 1'b1) && (n < 100));
      if (ack[inst] !== 1'b1) begin
         checks++;
         $display("FAIL ack_timeout: inst %0d addr %h got no ack expected ack within 100 cycles", inst, a);
      end
      req = 1'b0; we = 1'b0;
      @(negedge clk);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         if (ack[i]) begin
            chk("ack_gap", {31'b0, prevAck[i]}, 32'd0);
            if (expQ.size() == 0) begin
               checks++;
               $display("FAIL unexpected_ack: inst %0d rdata %h err %b expected no ack", i, rdata[i], err[i]);
            end else begin
               e = expQ.pop_front();
               chk("rdata", rdata[i], e.rdata);
               chk("err", {31'b0, err[i]}, {31'b0, e.err});
               chk("latency", cyc, e.cyc);
            end
         end else if (prevAck[i]) begin
            chk("rdata_clear", rdata[i], 32'd0);
         end
         if (wrEn[i]) begin
            if (txQ.size() == 0) begin
               checks++;
               $display("FAIL unexpected_push: inst %0d tx_data %h expected no push", i, txData[i]);
            end else begin
               chk("tx_data", {24'b0, txData[i]}, {24'b0, txQ.pop_front()});
            end
         end
      end
      prevAck = ack;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 3'b000; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; full = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_ack", {31'b0, ack[i]}, 32'd0);
         chk("rst_err", {31'b0, err[i]}, 32'd0);
         chk("rst_rdata", rdata[i], 32'd0);
         chk("rst_wr_en", {31'b0, wrEn[i]}, 32'd0);
         chk("rst_tx_data", {24'b0, txData[i]}, 32'd0);
      end

      // Instance A: blocking, no timeout
      rstn = 3'b001;
      @(negedge clk);
      pushRx(8'h41); pushRx(8'h42);
      repeat (4) @(negedge clk);
      access(1'b0, RXA,   '0, 32'h41, 1'b0, 0, 0);
      access(1'b0, RXA,   '0, 32'h42, 1'b0, 0, 0);
      access(1'b0, RXSTA, '0, 32'h0,  1'b0, 0, 0);

      for (int b = 0; b < 6; b++) pushRx(8'h10 + 8'(b));
      repeat (8) @(negedge clk);
      chk("fifo_left", rxWr - rxRd, 32'd2);
      access(1'b0, RXSTA, '0, 32'h0000_0401, 1'b0, 0, 0);
      access(1'b0, TXSTA, '0, 32'h1, 1'b0, 0, 0);
      full = 1'b1;
      access(1'b0, TXSTA, '0, 32'h0, 1'b0, 0, 0);
      full = 1'b0;
      for (int b = 0; b < 6; b++) access(1'b0, RXA, '0, 32'h10 + b, 1'b0, 0, 0);

      pushRx(8'h20); pushRx(8'h21); pushRx(8'h22);
      repeat (6) @(negedge clk);
      access(1'b0, RXSTA, '0, 32'h0000_0301, 1'b0, 0, 0);
      pushRx(8'h23);
      access(1'b0, RXA,   '0, 32'h20, 1'b0, 0, 0);
      access(1'b0, RXSTA, '0, 32'h0000_0301, 1'b0, 0, 0);
      access(1'b0, RXA,   '0, 32'h21, 1'b0, 0, 0);
      access(1'b0, RXA,   '0, 32'h22, 1'b0, 0, 0);
      access(1'b0, RXA,   '0, 32'h23, 1'b0, 0, 0);
      access(1'b0, RXSTA, '0, 32'h0, 1'b0, 0, 0);

      fork
         access(1'b0, RXA, '0, 32'h55, 1'b0, 21, 0);
         begin
            repeat (20) @(negedge clk);
            pushRx(8'h55);
         end
      join

      // Reset in the middle of a blocked RX read
      req = 1'b1; we = 1'b0; addr = RXA;
      repeat (5) @(negedge clk);
      #2;
      rstn[0] = 1'b0;
      req = 1'b0;
      pushRx(8'h56);
      #1;
      chk("midrst_ack", {31'b0, ack[0]}, 32'd0);
      chk("midrst_err", {31'b0, err[0]}, 32'd0);
      chk("midrst_rdata", rdata[0], 32'd0);
      chk("midrst_rd_en", {31'b0, rdEn[0]}, 32'd0);
      chk("midrst_wr_en", {31'b0, wrEn[0]}, 32'd0);
      @(negedge clk);
      rstn = 3'b001;
      access(1'b0, RXSTA, '0, 32'h0, 1'b0, 0, 0);
      access(1'b0, RXA,   '0, 32'h56, 1'b0, 0, 0);

      // Instance B: blocking, TIMEOUT=8
      rstn = 3'b010;
      repeat (2) @(negedge clk);
      full = 1'b1;
      access(1'b1, TXA, 32'h0000_007E, 32'h0, 1'b1, 8, 1);
      repeat (2) @(negedge clk);
      txQ.push_back(8'h7E);
      fork
         access(1'b1, TXA, 32'hFFFF_FF7E, 32'h0, 1'b0, 3, 1);
         begin
            repeat (3) @(negedge clk);
            full = 1'b0;
         end
      join
      txQ.push_back(8'h33);
      access(1'b1, TXA, 32'h0000_0033, 32'h0, 1'b0, 0, 1);
      access(1'b1, RXA, 32'h0000_0099, 32'h0, 1'b0, 0, 1);

      // Instance C: nonblocking
      rstn = 3'b100;
      repeat (2) @(negedge clk);
      access(1'b0, RXA,     '0, 32'h0, 1'b1, 0, 2);
      access(1'b0, 10'h010, '0, 32'h0, 1'b0, 0, 2);
      full = 1'b1;
      access(1'b1, TXA, 32'h0000_00AA, 32'h0, 1'b1, 0, 2);
      access(1'b0, TXSTA, '0, 32'h0, 1'b0, 0, 2);
      full = 1'b0;
      access(1'b1, RXSTA, 32'h0000_0011, 32'h0, 1'b0, 0, 2);
      access(1'b0, TXA,   '0, 32'h0, 1'b0, 0, 2);
      access(1'b0, TXSTA, '0, 32'h1, 1'b0, 0, 2);

      repeat (4) @(negedge clk);
      chk("expq_empty", expQ.size(), 32'd0);
      chk("txq_empty", txQ.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
